// File: rtl/prog_count_ras.sv
// Program counter with a hardware return-address stack for instruction fetch.
// Ports: clk, rst_n, stall/ret/call/loadPC/relPC/incPC requests, altPC, offset,
//        ins_mem (registered PC), sp, stack_full, stack_empty, stack_err.
module prog_count_ras #(
  parameter int unsigned     AW         = 8,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [AW-1:0]   RESET_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         incPC,
  input  logic                         loadPC,
  input  logic                         relPC,
  input  logic                         call,
  input  logic                         ret,
  input  logic [AW-1:0]                altPC,
  input  logic [AW-1:0]                offset,
  output logic [AW-1:0]                ins_mem,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         stack_err
);

  localparam int unsigned SPW = $clog2(DEPTH+1);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  r_pc;
  logic [SPW-1:0] r_sp;
  logic           r_err;
  logic [AW-1:0]  r_stack [DEPTH];

  logic [AW-1:0]  w_pc_nx;
  logic [SPW-1:0] w_sp_nx;
  logic           w_err_nx;
  logic           w_push;
  logic [AW-1:0]  w_pc_inc;
  logic [SPW-1:0] w_spm1;
  logic [IW-1:0]  w_ridx;
  logic [IW-1:0]  w_widx;
  logic           w_full;
  logic           w_empty;

  assign w_full   = (r_sp == SPW'(DEPTH));
  assign w_empty  = (r_sp == '0);
  assign w_pc_inc = r_pc + AW'(1);
  assign w_spm1   = r_sp - SPW'(1);
  assign w_ridx   = IW'(w_spm1);
  assign w_widx   = IW'(r_sp);

  // Fixed priority: stall > ret > call > loadPC > relPC > incPC > hold.
  // Rejected ret/call leave PC and sp alone and only raise the error pulse.
  always_comb begin
    w_pc_nx  = r_pc;
    w_sp_nx  = r_sp;
    w_err_nx = 1'b0;
    w_push   = 1'b0;
    if (stall) begin
      w_pc_nx = r_pc;
    end else if (ret) begin
      if (w_empty) begin
        w_err_nx = 1'b1;
      end else begin
        w_pc_nx = r_stack[w_ridx];
        w_sp_nx = w_spm1;
      end
    end else if (call) begin
      if (w_full) begin
        w_err_nx = 1'b1;
      end else begin
        w_push  = 1'b1;
        w_pc_nx = altPC;
        w_sp_nx = r_sp + SPW'(1);
      end
    end else if (loadPC) begin
      w_pc_nx = altPC;
    end else if (relPC) begin
      w_pc_nx = r_pc + offset;
    end else if (incPC) begin
      w_pc_nx = w_pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_ADDR;
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_nx;
      r_sp  <= w_sp_nx;
      r_err <= w_err_nx;
    end
  end

  // Stack storage is never cleared; entries at or above sp are dead.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_stack[w_widx] <= w_pc_inc;
    end
  end

  assign ins_mem     = r_pc;
  assign sp          = r_sp;
  assign stack_err   = r_err;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;

endmodule

// File: tb/tb_prog_count_ras.sv
// Testbench for prog_count_ras: directed vector table, async-reset sequence,
// then random requests checked against a queue-based reference model.
module tb_prog_count_ras;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          stall, incPC, loadPC, relPC, call, ret;
  logic [AW-1:0] altPC, offset;
  logic [AW-1:0] ins_mem;
  logic [2:0]    sp;
  logic          stack_full, stack_empty, stack_err;

  prog_count_ras #(.AW(AW), .DEPTH(DEPTH), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .stall(stall), .incPC(incPC), .loadPC(loadPC), .relPC(relPC),
    .call(call), .ret(ret),
    .altPC(altPC), .offset(offset),
    .ins_mem(ins_mem), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          st, rt, cl, ld, rl, in;
    logic [AW-1:0] alt, off;
    logic [AW-1:0] epc;
    int            esp;
    logic          eerr;
  } vec_t;

  int n_vec;
  int n_err;

  // Reference model: PC value plus a queue of return addresses.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_q[$];
  logic          m_err;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [AW-1:0] epc, int esp, logic eerr);
    chk({tag, " ins_mem"}, 32'(ins_mem), 32'(epc));
    chk({tag, " sp"}, 32'(sp), 32'(esp));
    chk({tag, " stack_err"}, 32'(stack_err), 32'(eerr));
    chk({tag, " stack_full"}, 32'(stack_full), 32'(esp == DEPTH));
    chk({tag, " stack_empty"}, 32'(stack_empty), 32'(esp == 0));
  endtask

  task automatic model(vec_t v);
    m_err = 1'b0;
    if (v.st) begin
      m_err = 1'b0;
    end else if (v.rt) begin
      if (m_q.size() == 0) m_err = 1'b1;
      else m_pc = m_q.pop_back();
    end else if (v.cl) begin
      if (m_q.size() == DEPTH) m_err = 1'b1;
      else begin
        m_q.push_back(m_pc + 8'd1);
        m_pc = v.alt;
      end
    end else if (v.ld) m_pc = v.alt;
    else if (v.rl) m_pc = m_pc + v.off;
    else if (v.in) m_pc = m_pc + 8'd1;
  endtask

  task automatic drive(vec_t v);
    stall = v.st; ret = v.rt; call = v.cl;
    loadPC = v.ld; relPC = v.rl; incPC = v.in;
    altPC = v.alt; offset = v.off;
  endtask

  task automatic idle();
    stall = 0; ret = 0; call = 0; loadPC = 0; relPC = 0; incPC = 0;
    altPC = '0; offset = '0;
  endtask

  function automatic vec_t mk(logic st, logic rt, logic cl, logic ld,
                              logic rl, logic in, logic [7:0] alt,
                              logic [7:0] off, logic [7:0] epc, int esp,
                              logic eerr);
    vec_t v;
    v.st = st; v.rt = rt; v.cl = cl; v.ld = ld; v.rl = rl; v.in = in;
    v.alt = alt; v.off = off; v.epc = epc; v.esp = esp; v.eerr = eerr;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    n_vec = 0;
    n_err = 0;
    m_pc  = 8'h00;
    m_err = 1'b0;
    rst_n = 1'b0;
    idle();

    //              st rt cl ld rl in alt    off    epc    sp err
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h01, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h02, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h03, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'hFF, 8'h00, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h10, 8'h00, 8'h10, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'hFC, 8'h0C, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h02, 8'h00, 8'h02, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'hFC, 8'hFE, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h05, 8'h00, 8'h05, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h40, 8'h00, 8'h40, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h80, 8'h00, 8'h80, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h41, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h06, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h06, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h07, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h10, 8'h00, 8'h10, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h20, 8'h00, 8'h20, 2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h30, 8'h00, 8'h30, 3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h50, 8'h00, 8'h50, 4, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h99, 8'h00, 8'h50, 4, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 8'h99, 8'h00, 8'h50, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h31, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h21, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 8'h77, 8'h00, 8'h08, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 8'h33, 8'h00, 8'h33, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h60, 8'h00, 8'h60, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h34, 0, 0));

    // Reset state while rst_n is held low across clock edges.
    #2;
    chk_all("reset0", 8'h00, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset1", 8'h00, 0, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      model(tbl[i]);
      @(posedge clk);
      #1;
      chk_all($sformatf("tbl%0d", i), tbl[i].epc, tbl[i].esp, tbl[i].eerr);
    end

    // Three calls, then async reset dropped between clock edges.
    for (int k = 0; k < 3; k++) begin
      idle();
      call = 1'b1;
      altPC = 8'(8'hA0 + k);
      @(posedge clk);
      #1;
    end
    idle();
    chk_all("pre_areset", 8'hA2, 3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("areset", 8'h00, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ret = 1'b1;
    @(posedge clk);
    #1;
    chk_all("ret_after_rst", 8'h00, 0, 1'b1);
    idle();
    m_pc = 8'h00;
    m_q.delete();

    // Random requests against the reference model.
    for (int r = 0; r < 400; r++) begin
      vec_t v;
      v = mk($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
             8'($urandom), 8'($urandom), 8'h00, 0, 1'b0);
      drive(v);
      model(v);
      @(posedge clk);
      #1;
      chk_all($sformatf("rnd%0d", r), m_pc, m_q.size(), m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_count_ras.md
# prog_count_ras

Parametrised program counter with a hardware return-address stack (RAS), replacing the fixed 4-bit increment/load counter in the instruction-fetch path. It drives the instruction memory address and supports hold, increment, absolute load, PC-relative branch, subroutine call and return. One request is applied per clock, resolved by fixed priority. Overflow and underflow of the stack are flagged rather than corrupting state.

## Interface
- AW, 8: address width in bits; PC and all address arithmetic are AW bits, modulo 2^AW.
- DEPTH, 4: return-stack entries, at least 1.
- RESET_ADDR, 0: PC value after reset, AW bits.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  freezes PC and stack; overrides all other requests.
- incPC  input  1  PC <= PC + 1.
- loadPC  input  1  PC <= altPC.
- relPC  input  1  PC <= PC + offset.
- call  input  1  push PC + 1, then PC <= altPC.
- ret  input  1  PC <= top of stack, then pop.
- altPC  input  AW  absolute target for loadPC and call.
- offset  input  AW  two's-complement displacement for relPC.
- ins_mem  output  AW  current PC, registered.
- sp  output  $clog2(DEPTH+1)  number of valid stack entries.
- stack_full  output  1  sp == DEPTH, combinational from sp.
- stack_empty  output  1  sp == 0, combinational from sp.
- stack_err  output  1  registered one-cycle pulse flagging a rejected call or ret.

## Operation
- Priority, highest first: stall, ret, call, loadPC, relPC, incPC, then hold. Exactly one action is taken per cycle; lower-priority requests in the same cycle are discarded.
- stall: PC, stack and sp unchanged; stack_err <= 0.
- ret with sp > 0: ins_mem <= stack[sp-1]; sp <= sp - 1.
- ret with sp == 0 (underflow): PC and sp unchanged; stack_err <= 1.
- call with sp < DEPTH: stack[sp] <= ins_mem + 1 (wraps); ins_mem <= altPC; sp <= sp + 1.
- call with sp == DEPTH (overflow): whole call rejected, no push and no jump; PC unchanged; stack_err <= 1.
- loadPC: ins_mem <= altPC.
- relPC: ins_mem <= ins_mem + offset, sign-extended arithmetic truncated to AW bits. Wrap-around in either direction is legal and unflagged.
- incPC: ins_mem <= ins_mem + 1. 2^AW-1 wraps to 0.
- stack_err is 0 in every cycle that does not reject a call or ret.
- Stack entries at or above sp are don't-care and must never reach ins_mem.

## Timing
- Reset: asynchronous assert and synchronous-safe deassert. While rst_n is 0: ins_mem = RESET_ADDR, sp = 0, stack_err = 0, stack_full = 0, stack_empty = 1. Stack contents are not cleared.
- Reset asserted mid-operation, including mid call/ret, takes effect immediately without waiting for a clock edge. The first edge after release performs a normal request.
- Latency: a request sampled at edge N is visible on ins_mem, sp and stack_err after edge N. No combinational path exists from any input to ins_mem.
- Back-to-back call/ret on consecutive cycles is fully supported with no bubbles. A ret in the cycle after a call returns to the caller's PC + 1.
- Requests in the same cycle as a rejected call or ret are not retried and not applied.

## Test plan
- Reset and increment, AW=8, RESET_ADDR=0: hold rst_n low, then 3 cycles of incPC -> ins_mem 0,1,2,3. Then load 0xFF followed by incPC -> 0x00.
- Relative branch: ins_mem=0x10 with relPC and offset=0xFC (-4) -> 0x0C. Then ins_mem=0x02 with offset=0xFC -> 0xFE (wrap).
- Nested calls, DEPTH=4: from PC=0x05, call to 0x40 then call to 0x80 -> sp=2. ret -> 0x41; ret -> 0x06, sp=0, stack_empty=1.
- Overflow and underflow: 4 calls make stack_full=1. A 5th call to 0x99 -> PC unchanged, sp=4, one-cycle stack_err. With sp=0, ret -> PC unchanged, stack_err pulse.
- Priority and stall: stall with call and ret asserted -> no change. ret+call+incPC with sp=1 -> only ret taken. loadPC+incPC with altPC=0x33 -> 0x33.
- Async reset mid-sequence: drop rst_n between clock edges with sp=3 -> ins_mem=RESET_ADDR and sp=0 immediately. A ret after release -> stack_err.
